sync_fifo_gen2: RTL and testbench
=================================

Name: sync_fifo_gen2

Overview:
Parametrised synchronous FIFO, next generation of the team's single-clock byte FIFO. Generalises data width and depth. Adds:
- fill-level count output
- programmable almost-full and almost-empty thresholds
- overflow and underflow error pulses
- selectable first-word-fall-through (FWFT) read mode

Sits between single-clock producer/consumer blocks as elastic buffering.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AFULL_TH, DEPTH-2, almost_full_o asserted when count >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 1, almost_empty_o asserted when count <= AEMPTY_TH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
CNT_W, $clog2(DEPTH+1), width of count_o (derived, not overridden)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en_i  in  1  write request
data_i  in  DATA_W  write data
rd_en_i  in  1  read request (FWFT: pop/acknowledge of head word)
data_o  out  DATA_W  read data
rd_valid_o  out  1  data_o holds a newly read word (standard mode); equals !empty_o in FWFT
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
almost_full_o  out  1  count >= AFULL_TH
almost_empty_o  out  1  count <= AEMPTY_TH
count_o  out  CNT_W  current occupancy, 0..DEPTH
overflow_o  out  1  one-cycle pulse: write requested but rejected
underflow_o  out  1  one-cycle pulse: read requested but rejected

Behaviour:
- Reset (rst high at a clock edge) overrides all other inputs. After reset:
  - pointers and count_o = 0
  - empty_o = 1, full_o = 0
  - almost_empty_o = 1, almost_full_o = 0
  - data_o = 0, rd_valid_o = 0
  - overflow_o = 0, underflow_o = 0
- Reset mid-operation discards contents. Memory array is not cleared.
- Read accepted (rd_ok) = rd_en_i && !empty_o.
- Write accepted (wr_ok) = wr_en_i && (!full_o || rd_ok). When full, a simultaneous read and write both succeed and count is unchanged.
- When empty, a simultaneous read and write: the write is accepted, the read is rejected (underflow_o pulses), count becomes 1.
- Count update:
  - count +1 on wr_ok && !rd_ok
  - count -1 on rd_ok && !wr_ok
  - otherwise unchanged
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full/empty are decoded from count_o, not from pointer equality.
- All flags are decoded from registered state (count, pointers, error regs). They change on the same edge as count_o, with no extra cycle of latency and no combinational path from wr_en_i/rd_en_i to any flag.
- overflow_o: high for the cycle after an edge where wr_en_i && !wr_ok. underflow_o: same rule for reads. The FIFO state is unaffected by the rejected request.
- Standard mode (FWFT=0):
  - On an rd_ok edge, data_o <= mem[rd_ptr] and rd_valid_o <= 1; otherwise rd_valid_o <= 0 and data_o holds.
  - Read latency is 1 cycle.
  - A word written at edge N is readable via rd_en_i from edge N+1 (no write-through bypass).
- FWFT mode (FWFT=1):
  - data_o = mem[rd_ptr] whenever !empty_o; rd_valid_o = !empty_o.
  - rd_en_i pops the head at the edge; the next word appears after that edge.
  - A write into an empty FIFO at edge N is visible on data_o after edge N.
  - When empty_o = 1, data_o holds its last value.
- The enforced threshold ranges guarantee each almost flag asserts at some occupancy. Out-of-range parameters are rejected at elaboration via a generate-time error.

Decomposition:
- fifo_pkg holds:
  - mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1
  - a clog2 helper function
  - default threshold constants
- One sub-module, fifo_sdp_ram:
  - DATA_W x DEPTH simple dual-port memory
  - synchronous write port
  - asynchronous read port; the top adds the output register for standard mode
- Pointer/count/flag logic stays in sync_fifo_gen2.

Test Plan:
Bench configuration: DEPTH=8, DATA_W=8, AFULL_TH=6, AEMPTY_TH=1, FWFT=0 unless stated.
1. Reset then idle -> empty_o=1, almost_empty_o=1, full_o=0, count_o=0, data_o=0, no error pulses.
2. Write 0..7 on consecutive cycles:
   - almost_empty_o drops when count=2
   - almost_full_o rises when count=6
   - full_o=1 at count=8
   - a 9th write (data 8'hAA) -> overflow_o pulses once, count stays 8
3. From full, read 8 words:
   - data_o = 0..7, each with a 1-cycle latency rd_valid_o pulse
   - empty_o=1 after the 8th read
   - a 9th read -> underflow_o pulses, data_o holds 7
4. Wrap-around: write 5, read 5, write 8 (data 8'h10..8'h17), read 8 -> data_o = 8'h10..8'h17 in order, count_o returns to 0.
5. Simultaneous traffic:
   - at full, wr+rd same cycle -> count_o stays 8, no overflow
   - at empty, wr+rd same cycle -> underflow_o pulses, count_o=1
6. FWFT=1: write 8'h5A into empty -> next cycle data_o=8'h5A, rd_valid_o=1 without rd_en_i. Then assert rst with 3 entries -> count_o=0, empty_o=1 on the following cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

    // Read-mode selector values for the FWFT parameter
    localparam int FIFO_MODE_STD  = 32'sd0;
    localparam int FIFO_MODE_FWFT = 32'sd1;

    // Default almost-full margin below DEPTH and default almost-empty level
    localparam int FIFO_AFULL_MARGIN  = 32'sd2;
    localparam int FIFO_AEMPTY_TH_DEF = 32'sd1;

    // Ceiling log2 usable in constant expressions; returns 0 for values <= 1
    function automatic int fifo_clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 32'sd1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Contents are deliberately not reset; occupancy tracking lives in the top.
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int ADDR_W = fifo_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Store the incoming word at the write address
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/sync_fifo_gen2.sv
// Parametrised single-clock FIFO with fill count, almost flags, error pulses
// and a selectable first-word-fall-through read mode. All flags are
// registered alongside the count so they move on the same edge.
module sync_fifo_gen2
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - FIFO_AFULL_MARGIN,
    parameter int AEMPTY_TH = FIFO_AEMPTY_TH_DEF,
    parameter int FWFT      = FIFO_MODE_STD,
    localparam int CNT_W    = fifo_clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] data_o,
    output logic              rd_valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int PTR_W = fifo_clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    // Reject parameter sets where a flag could never assert or the pointer
    // wrap would not line up with the storage depth
    if (DATA_W < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        AFULL_TH < 1 || AFULL_TH > DEPTH ||
        AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1 ||
        (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT)) begin : g_param_error
        $error("sync_fifo_gen2: illegal parameter combination");
    end

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              rd_ok_s;
    logic              wr_ok_s;
    logic              full_r;
    logic              empty_r;
    logic              afull_r;
    logic              aempty_r;
    logic              ovf_r;
    logic              unf_r;
    logic [DATA_W-1:0] data_r;
    logic              rd_valid_r;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] ram_rd_data_s;

    fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok_s),
        .wr_addr (wr_ptr_r),
        .wr_data (data_i),
        .rd_addr (rd_ptr_r),
        .rd_data (ram_rd_data_s)
    );

    // Accept/reject decisions and next occupancy; a read on empty is refused
    // even when a write lands in the same cycle
    always_comb begin
        rd_ok_s     = rd_en_i && !empty_r;
        wr_ok_s     = wr_en_i && (!full_r || rd_ok_s);
        count_nxt_s = count_r;
        if (wr_ok_s && !rd_ok_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (rd_ok_s && !wr_ok_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, count, occupancy flags and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == DEPTH_C);
            empty_r  <= (count_nxt_s == '0);
            afull_r  <= (count_nxt_s >= AFULL_C);
            aempty_r <= (count_nxt_s <= AEMPTY_C);
            ovf_r    <= wr_en_i && !wr_ok_s;
            unf_r    <= rd_en_i && !rd_ok_s;
        end
    end

    // Read-side registers: standard-mode output word/valid, and the last
    // head word so FWFT mode can hold data_o while empty
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r     <= '0;
            rd_valid_r <= 1'b0;
            hold_r     <= '0;
        end else begin
            if (rd_ok_s) begin
                data_r <= ram_rd_data_s;
            end
            rd_valid_r <= rd_ok_s;
            if (!empty_r) begin
                hold_r <= ram_rd_data_s;
            end
        end
    end

    // Select the read presentation for the configured mode
    always_comb begin
        if (FWFT == FIFO_MODE_FWFT) begin
            rd_valid_o = !empty_r;
            if (empty_r) begin
                data_o = hold_r;
            end else begin
                data_o = ram_rd_data_s;
            end
        end else begin
            rd_valid_o = rd_valid_r;
            data_o     = data_r;
        end
    end

    assign full_o         = full_r;
    assign empty_o        = empty_r;
    assign almost_full_o  = afull_r;
    assign almost_empty_o = aempty_r;
    assign count_o        = count_r;
    assign overflow_o     = ovf_r;
    assign underflow_o    = unf_r;

endmodule

// File: tb/tb_sync_fifo_gen2.sv
// Self-checking bench: a standard-mode and an FWFT-mode FIFO receive the
// same stimulus and are compared every cycle against a queue-based model.
module tb_sync_fifo_gen2;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;

    logic [7:0] s_data, f_data;
    logic       s_valid, f_valid, s_full, f_full, s_empty, f_empty;
    logic       s_afull, f_afull, s_aempty, f_aempty;
    logic [3:0] s_count, f_count;
    logic       s_ovf, f_ovf, s_unf, f_unf;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [7:0] mq [$];
    logic [7:0] exp_std_data;
    logic       exp_std_valid;
    logic       exp_ovf;
    logic       exp_unf;
    logic [7:0] fwft_last;

    sync_fifo_gen2 #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .data_i(data_in), .rd_en_i(rd_en),
        .data_o(s_data), .rd_valid_o(s_valid), .full_o(s_full), .empty_o(s_empty),
        .almost_full_o(s_afull), .almost_empty_o(s_aempty), .count_o(s_count),
        .overflow_o(s_ovf), .underflow_o(s_unf)
    );

    sync_fifo_gen2 #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .data_i(data_in), .rd_en_i(rd_en),
        .data_o(f_data), .rd_valid_o(f_valid), .full_o(f_full), .empty_o(f_empty),
        .almost_full_o(f_afull), .almost_empty_o(f_aempty), .count_o(f_count),
        .overflow_o(f_ovf), .underflow_o(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, compare both DUTs
    task automatic step(input logic r, input logic w, input logic [7:0] d, input logic rd);
        bit         rd_ok, wr_ok;
        int         sz;
        logic [7:0] exp_f_data;
        rst = r; wr_en = w; data_in = d; rd_en = rd;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            exp_std_data  = 8'h00;
            exp_std_valid = 1'b0;
            exp_ovf       = 1'b0;
            exp_unf       = 1'b0;
            fwft_last     = 8'h00;
        end else begin
            if (mq.size() > 0) fwft_last = mq[0];
            rd_ok = rd && (mq.size() > 0);
            wr_ok = w && ((mq.size() < 8) || rd_ok);
            exp_ovf = w && !wr_ok;
            exp_unf = rd && !rd_ok;
            exp_std_valid = rd_ok;
            if (rd_ok) exp_std_data = mq.pop_front();
            if (wr_ok) mq.push_back(d);
        end
        sz = mq.size();
        exp_f_data = (sz > 0) ? mq[0] : fwft_last;

        check_val("std_count",  32'(s_count),  32'(sz));
        check_val("std_full",   32'(s_full),   32'(sz == 8));
        check_val("std_empty",  32'(s_empty),  32'(sz == 0));
        check_val("std_afull",  32'(s_afull),  32'(sz >= 6));
        check_val("std_aempty", 32'(s_aempty), 32'(sz <= 1));
        check_val("std_ovf",    32'(s_ovf),    32'(exp_ovf));
        check_val("std_unf",    32'(s_unf),    32'(exp_unf));
        check_val("std_valid",  32'(s_valid),  32'(exp_std_valid));
        check_val("std_data",   32'(s_data),   32'(exp_std_data));
        check_val("fwft_count", 32'(f_count),  32'(sz));
        check_val("fwft_full",  32'(f_full),   32'(sz == 8));
        check_val("fwft_empty", 32'(f_empty),  32'(sz == 0));
        check_val("fwft_afull", 32'(f_afull),  32'(sz >= 6));
        check_val("fwft_aempty",32'(f_aempty), 32'(sz <= 1));
        check_val("fwft_ovf",   32'(f_ovf),    32'(exp_ovf));
        check_val("fwft_unf",   32'(f_unf),    32'(exp_unf));
        check_val("fwft_valid", 32'(f_valid),  32'(sz > 0));
        check_val("fwft_data",  32'(f_data),   32'(exp_f_data));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; data_in = 8'h00; rd_en = 1'b0;
        mq.delete();
        exp_std_data = 8'h00; exp_std_valid = 1'b0;
        exp_ovf = 1'b0; exp_unf = 1'b0; fwft_last = 8'h00;

        // 1: reset then idle
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // 2: fill 0..7, then an overflowing 9th write
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // 3: drain 8 words, then an underflowing 9th read
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // 4: wrap-around
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // 5: simultaneous read/write at full and at empty
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h66, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // 6: write into empty shows immediately in FWFT; reset with 3 entries
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h5A, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h5B, 1'b0);
        step(1'b0, 1'b1, 8'h5C, 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // random traffic in phases of varying write/read bias
        for (int ph = 0; ph < 12; ph++) begin
            int wp, rp;
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int c = 0; c < 250; c++) begin
                step(($urandom_range(0, 299) == 0),
                     ($urandom_range(0, 99) < wp),
                     8'($urandom),
                     ($urandom_range(0, 99) < rp));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
